// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The encoder takes the slave side; a program generator or bench takes the master side.
interface instr_encoder_if;
    logic        iValid;
    logic        oReady;
    logic [2:0]  iFmt;
    logic [6:0]  iOpcode;
    logic [4:0]  iRd;
    logic [4:0]  iRs1;
    logic [4:0]  iRs2;
    logic [2:0]  iFunct3;
    logic [31:0] iImm;
    logic        oValid;
    logic        iReady;
    logic [31:0] oInstr;
    logic        oErr;
    logic        oLast;

    modport slave (
        input  iValid, iFmt, iOpcode, iRd, iRs1, iRs2, iFunct3, iImm, iReady,
        output oReady, oValid, oInstr, oErr, oLast
    );

    modport master (
        output iValid, iFmt, iOpcode, iRd, iRs1, iRs2, iFunct3, iImm, iReady,
        input  oReady, oValid, oInstr, oErr, oLast
    );
endinterface

// File: rtl/instr_encoder.sv
// Registered RV32I instruction encoder: packs I/S/B/J/U words and expands `li`
// into ADDI, LUI or LUI+ADDI, with range/alignment flags on the immediate.
module instr_encoder (
    input  logic           iCLK,
    input  logic           iRST,
    instr_encoder_if.slave enc
);
    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        EMIT_LO
    } state_e;

    localparam logic [2:0]  FMT_I      = 3'd0;
    localparam logic [2:0]  FMT_S      = 3'd1;
    localparam logic [2:0]  FMT_B      = 3'd2;
    localparam logic [2:0]  FMT_J      = 3'd3;
    localparam logic [2:0]  FMT_U      = 3'd4;
    localparam logic [2:0]  FMT_LI     = 3'd5;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] lo_word_q, lo_word_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic        two_q, two_d;

    logic [31:0] imm;
    logic        fits12, fits13, fits21;
    logic [19:0] li_hi;
    logic [31:0] enc_word, enc_lo_word;
    logic        enc_err, enc_two;

    // Encode the request as presented; the words are captured only on accept.
    always_comb begin
        imm    = enc.iImm;
        fits12 = (imm[31:11] == {21{imm[11]}});
        fits13 = (imm[31:12] == {20{imm[12]}});
        fits21 = (imm[31:20] == {12{imm[20]}});
        // Upper half of imm + 0x800: the low 12 bits carry out exactly when imm[11] is set.
        li_hi  = imm[31:12] + {19'd0, imm[11]};

        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        enc_word    = NOP_WORD;
        enc_lo_word = '0;
        enc_err     = 1'b0;
        enc_two     = 1'b0;

        case (enc.iFmt)
            FMT_I: begin
                enc_word = {imm[11:0], enc.iRs1, enc.iFunct3, enc.iRd, enc.iOpcode};
                enc_err  = !fits12;
            end
            FMT_S: begin
                enc_word = {imm[11:5], enc.iRs2, enc.iRs1, enc.iFunct3, imm[4:0], enc.iOpcode};
                enc_err  = !fits12;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], enc.iRs2, enc.iRs1, enc.iFunct3,
                            imm[4:1], imm[11], enc.iOpcode};
                enc_err  = imm[0] || !fits13;
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], enc.iRd, enc.iOpcode};
                enc_err  = imm[0] || !fits21;
            end
            FMT_U: begin
                enc_word = {imm[31:12], enc.iRd, enc.iOpcode};
                enc_err  = (imm[11:0] != 12'd0);
            end
            FMT_LI: begin
                if (fits12) begin
                    enc_word = {imm[11:0], 5'd0, 3'b000, enc.iRd, OPC_OP_IMM};
                end else if (imm[11:0] == 12'd0) begin
                    enc_word = {imm[31:12], enc.iRd, OPC_LUI};
                end else begin
                    enc_word    = {li_hi, enc.iRd, OPC_LUI};
                    enc_lo_word = {imm[11:0], enc.iRd, 3'b000, enc.iRd, OPC_OP_IMM};
                    enc_two     = 1'b1;
                end
            end
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        lo_word_d = lo_word_q;
        err_d     = err_q;
        last_d    = last_q;
        two_d     = two_q;

        case (state_q)
            IDLE: begin
                if (enc.iValid) begin
                    state_d   = EMIT;
                    instr_d   = enc_word;
                    lo_word_d = enc_lo_word;
                    err_d     = enc_err;
                    last_d    = !enc_two;
                    two_d     = enc_two;
                end
            end
            EMIT: begin
                if (enc.iReady) begin
                    if (two_q) begin
                        state_d = EMIT_LO;
                        instr_d = lo_word_q;
                        err_d   = 1'b0;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            EMIT_LO: begin
                if (enc.iReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            lo_word_q <= '0;
            err_q     <= 1'b0;
            last_q    <= 1'b0;
            two_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            lo_word_q <= lo_word_d;
            err_q     <= err_d;
            last_q    <= last_d;
            two_q     <= two_d;
        end
    end

    assign enc.oReady = (state_q == IDLE);
    assign enc.oValid = (state_q != IDLE);
    assign enc.oInstr = instr_q;
    assign enc.oErr   = err_q;
    assign enc.oLast  = last_q;
endmodule
